// File: rtl/rle_enc.sv
// rle_enc: JPEG-style run-length encoder for one zigzag-ordered coefficient block
module rle_enc #(
  parameter int DATA_WIDTH = 10,
  parameter int BLK_SIZE   = 64,
  parameter int RUN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_in,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  in_rdy,
  output logic                  vld_out,
  output logic                  dc,
  output logic                  zrl,
  output logic                  eob,
  output logic                  last,
  output logic [RUN_WIDTH-1:0]  run,
  output logic [DATA_WIDTH-1:0] level
);
  localparam int IW = $clog2(BLK_SIZE);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [IW-1:0] ZRL_N = IW'(2 ** RUN_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(BLK_SIZE - 1);
  logic [0:0] state;
  logic [IW-1:0] idx, zcnt;
  logic [DATA_WIDTH-1:0] hold;
  logic hold_last;
  logic acc, big;
  always_comb begin
    acc = vld_in & in_rdy;
    big = zcnt >= ZRL_N;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      in_rdy <= 1'b1;
      idx <= '0;
      zcnt <= '0;
      hold <= '0;
      hold_last <= 1'b0;
      vld_out <= 1'b0;
      dc <= 1'b0;
      zrl <= 1'b0;
      eob <= 1'b0;
      last <= 1'b0;
      run <= '0;
      level <= '0;
    end else begin
      vld_out <= 1'b0;
      dc <= 1'b0;
      zrl <= 1'b0;
      eob <= 1'b0;
      last <= 1'b0;
      if (state == FLUSH) begin
        vld_out <= 1'b1;
        if (big) begin
          zrl <= 1'b1;
          run <= '1;
          level <= '0;
          zcnt <= zcnt - ZRL_N;
        end else begin
          run <= zcnt[RUN_WIDTH-1:0];
          level <= hold;
          last <= hold_last;
          zcnt <= '0;
          state <= RUN;
          in_rdy <= 1'b1;
        end
      end else if (acc) begin
        idx <= idx + IW'(1);
        if (idx == '0) begin
          vld_out <= 1'b1;
          dc <= 1'b1;
          run <= '0;
          level <= din;
          zcnt <= '0;
        end else if (din == '0 && idx != LAST_IDX) begin
          zcnt <= zcnt + IW'(1);
        end else if (din == '0) begin
          vld_out <= 1'b1;
          eob <= 1'b1;
          last <= 1'b1;
          run <= '0;
          level <= '0;
          zcnt <= '0;
        end else if (!big) begin
          vld_out <= 1'b1;
          run <= zcnt[RUN_WIDTH-1:0];
          level <= din;
          last <= idx == LAST_IDX;
          zcnt <= '0;
        end else begin
          // too many zeros for one run field: emit ZRL now, park the level until the flush drains
          vld_out <= 1'b1;
          zrl <= 1'b1;
          run <= '1;
          level <= '0;
          zcnt <= zcnt - ZRL_N;
          hold <= din;
          hold_last <= idx == LAST_IDX;
          state <= FLUSH;
          in_rdy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rle_enc.sv
// tb_rle_enc: randomized self-checking bench for rle_enc against a block-level run-length model
module tb_rle_enc;
  logic clk = 1'b0, rst = 1'b1, vld_in = 1'b0;
  logic [9:0] din = '0;
  logic in_rdy, vld_out, dc, zrl, eob, last;
  logic [3:0] run;
  logic [9:0] level;
  typedef struct packed {logic dc, zrl, eob, last; logic [3:0] run; logic [9:0] level;} word_t;
  word_t got[$], exp_q[$];
  logic [9:0] blk [64];
  int errors = 0, checks = 0, stalls = 0, exp_stalls = 0;
  rle_enc dut (.clk(clk), .rst(rst), .vld_in(vld_in), .din(din), .in_rdy(in_rdy),
    .vld_out(vld_out), .dc(dc), .zrl(zrl), .eob(eob), .last(last), .run(run), .level(level));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (vld_out) got.push_back(word_t'({dc, zrl, eob, last, run, level}));
    if (!in_rdy) stalls++;
  end
  // Expected word list for blk: DC, then (run,level) pairs with a ZRL per 16 zeros, EOB if the tail is zero
  function automatic void build_exp();
    int z = 0;
    word_t w;
    exp_q.delete();
    exp_stalls = 0;
    exp_q.push_back(word_t'({4'b1000, 4'd0, blk[0]}));
    for (int k = 1; k < 64; k++) begin
      if (blk[k] == 10'd0) z++;
      else begin
        while (z >= 16) begin
          exp_q.push_back(word_t'({4'b0100, 4'hf, 10'd0}));
          exp_stalls++;
          z -= 16;
        end
        exp_q.push_back(word_t'({4'b0000, 4'(z), blk[k]}));
        z = 0;
      end
    end
    if (blk[63] == 10'd0) exp_q.push_back(word_t'({4'b0010, 4'd0, 10'd0}));
    w = exp_q.pop_back();
    w.last = 1'b1;
    exp_q.push_back(w);
  endfunction
  task automatic send_block(input int n_coef, input int gap);
    for (int k = 0; k < n_coef; k++) begin
      int n = 0;
      logic acc = 1'b0;
      while (!acc) begin
        vld_in = $urandom_range(0, 99) >= gap;
        din = vld_in ? blk[k] : 10'($urandom);
        acc = vld_in && in_rdy;
        @(posedge clk);
        #1;
        n++;
        if (n > 200) begin
          errors++;
          checks++;
          $display("FAIL send_timeout idx=%0d", k);
          vld_in = 1'b0;
          return;
        end
      end
    end
    vld_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (vld_out !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs got vld_out=%b in_rdy=%b want 0 1", vld_out, in_rdy);
    end
    checks++;
    if ({dc, zrl, eob, last, run, level} !== 18'd0) begin
      errors++;
      $display("FAIL reset_fields got %h want 0", {dc, zrl, eob, last, run, level});
    end
    rst = 1'b0;
  endtask
  task automatic test_directed();
    int want_words [3] = '{3, 4, 5};
    int want_stalls [3] = '{0, 1, 3};
    for (int d = 0; d < 3; d++) begin
      foreach (blk[k]) blk[k] = 10'd0;
      if (d == 0) begin blk[0] = 10'd5; blk[1] = -10'sd3; end
      if (d == 1) begin blk[0] = 10'd1; blk[21] = 10'd7; end
      if (d == 2) begin blk[0] = 10'd2; blk[63] = -10'sd1; end
      build_exp();
      got.delete();
      stalls = 0;
      send_block(64, 0);
      checks++;
      if (got.size() != want_words[d] || got.size() != exp_q.size()) begin
        errors++;
        $display("FAIL directed%0d_count got %0d want %0d", d, got.size(), want_words[d]);
      end
      checks++;
      if (stalls != want_stalls[d]) begin
        errors++;
        $display("FAIL directed%0d_stalls got %0d want %0d", d, stalls, want_stalls[d]);
      end
      foreach (exp_q[i]) if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL directed%0d_word%0d got %h want %h", d, i, got[i], exp_q[i]);
        end
      end
    end
  endtask
  task automatic test_all_nonzero();
    foreach (blk[k]) blk[k] = 10'(k);
    build_exp();
    got.delete();
    stalls = 0;
    send_block(64, 40);
    checks++;
    if (got.size() != 64 || stalls != 0) begin
      errors++;
      $display("FAIL all_nonzero got words=%0d stalls=%0d want 64 0", got.size(), stalls);
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL all_nonzero_word%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask
  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      int dens = $urandom_range(1, 24);
      foreach (blk[k]) blk[k] = ($urandom_range(1, dens) == 1) ? 10'($urandom) : 10'd0;
      build_exp();
      got.delete();
      stalls = 0;
      send_block(64, 30);
      checks++;
      if (got.size() != exp_q.size() || stalls != exp_stalls) begin
        errors++;
        $display("FAIL random%0d got words=%0d stalls=%0d want %0d %0d", b, got.size(), stalls, exp_q.size(), exp_stalls);
      end
      foreach (exp_q[i]) if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random%0d_word%0d got %h want %h", b, i, got[i], exp_q[i]);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++) begin
      foreach (blk[k]) blk[k] = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'd0;
      if (p == 0) blk[0] = 10'd0;
      build_exp();
      got.delete();
      send_block(p == 1 ? 30 : 64, 0);
      if (p == 1) begin
        got.delete();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (got.size() != 0 || vld_out !== 1'b0 || in_rdy !== 1'b1) begin
          errors++;
          $display("FAIL mid_reset got words=%0d vld_out=%b in_rdy=%b want 0 0 1", got.size(), vld_out, in_rdy);
        end
        continue;
      end
      checks++;
      if (got.size() != exp_q.size()) begin
        errors++;
        $display("FAIL b2b%0d_count got %0d want %0d", p, got.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b%0d_word%0d got %h want %h", p, i, got[i], exp_q[i]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_all_nonzero();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
